// File: rtl/fb_arbiter_pkg.sv
// Shared types and defaults for the frame-buffer arbiter.
// Owner tags steer returned SRAM data; the fill FSM state lives here too.
package fb_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 17;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 90000;

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_RD,
    OWN_WR,
    OWN_FILL
  } owner_t;

  typedef enum logic {
    F_IDLE,
    F_RUN
  } fill_state_t;

  function automatic logic addr_oor(input logic [31:0] addr, input int unsigned depth);
    return addr >= depth;
  endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Client-side and SRAM-side signals of the frame-buffer arbiter.
// slave = arbiter view, master = clients plus SRAM data return.
interface fb_arbiter_if #(
  parameter int unsigned ADDR_W = fb_arb_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = fb_arb_pkg::DATA_W_DEF
);

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_rdata;
  logic              rd_rvalid;

  logic              fill_start;
  logic [DATA_W-1:0] fill_value;
  logic              fill_busy;
  logic              fill_done;

  logic              addr_err;
  logic              err_clr;

  logic [ADDR_W-1:0] sram_addr;
  logic              sram_we;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  disp_req, disp_addr,
    output disp_rdata, disp_rvalid,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    input  rd_valid, rd_addr,
    output rd_ready, rd_rdata, rd_rvalid,
    input  fill_start, fill_value,
    output fill_busy, fill_done,
    input  err_clr,
    output addr_err,
    output sram_addr, sram_we, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output disp_req, disp_addr,
    input  disp_rdata, disp_rvalid,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    output rd_valid, rd_addr,
    input  rd_ready, rd_rdata, rd_rvalid,
    output fill_start, fill_value,
    input  fill_busy, fill_done,
    output err_clr,
    input  addr_err,
    input  sram_addr, sram_we, sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/fb_fill_engine.sv
// Whole-buffer fill sequencer: writes the captured value to 0..DEPTH-1,
// advancing only in cycles where the arbiter grants it the slot.
module fb_fill_engine
  import fb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_value,
  input  logic              i_slot,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fill_state_t       r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_value;
  logic              r_busy;
  logic              r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= F_IDLE;
      r_cnt   <= '0;
      r_value <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        F_IDLE: begin
          if (i_start) begin
            r_value <= i_value;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= F_RUN;
          end
        end
        F_RUN: begin
          // busy drops on the same edge that raises done
          if (i_slot) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_ADDR) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= F_IDLE;
            end
          end
        end
        default: r_state <= F_IDLE;
      endcase
    end
  end

  assign o_req  = (r_state == F_RUN);
  assign o_addr = r_cnt;
  assign o_data = r_value;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display has absolute priority with a
// fixed 2-cycle read latency, host write/read share round-robin, fill takes idle slots.
module fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  fb_arbiter_if.slave  bus
);

  logic              w_disp_oor;
  logic              w_wr_oor;
  logic              w_rd_oor;
  logic              w_wr_ready;
  logic              w_rd_ready;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_slot;
  logic              w_err;

  logic              w_fill_req;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [DATA_W-1:0] w_fill_data;
  logic              w_fill_busy;
  logic              w_fill_done;

  owner_t            w_own;
  logic [ADDR_W-1:0] w_addr;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;
  logic              w_oor;

  logic              r_last_rd;
  owner_t            r_own1;
  owner_t            r_own2;
  logic              r_oor1;
  logic              r_oor2;
  logic [ADDR_W-1:0] r_sram_addr;
  logic              r_sram_we;
  logic [DATA_W-1:0] r_sram_wdata;
  logic [DATA_W-1:0] r_disp_rdata;
  logic              r_disp_rvalid;
  logic [DATA_W-1:0] r_rd_rdata;
  logic              r_rd_rvalid;
  logic              r_addr_err;

  assign w_disp_oor = addr_oor(32'(bus.disp_addr), DEPTH);
  assign w_wr_oor   = addr_oor(32'(bus.wr_addr), DEPTH);
  assign w_rd_oor   = addr_oor(32'(bus.rd_addr), DEPTH);

  // readies look only at the other port's valid, never their own
  assign w_wr_ready = reset && !bus.disp_req && (!bus.rd_valid || r_last_rd);
  assign w_rd_ready = reset && !bus.disp_req && (!bus.wr_valid || !r_last_rd);
  assign w_wr_fire  = bus.wr_valid && w_wr_ready;
  assign w_rd_fire  = bus.rd_valid && w_rd_ready;
  assign w_slot     = !bus.disp_req && !w_wr_fire && !w_rd_fire;

  assign w_err = (bus.disp_req && w_disp_oor) ||
                 (w_wr_fire && w_wr_oor) ||
                 (w_rd_fire && w_rd_oor);

  fb_fill_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fill (
    .clk     (clk),
    .reset   (reset),
    .i_start (bus.fill_start),
    .i_value (bus.fill_value),
    .i_slot  (w_slot),
    .o_req   (w_fill_req),
    .o_addr  (w_fill_addr),
    .o_data  (w_fill_data),
    .o_busy  (w_fill_busy),
    .o_done  (w_fill_done)
  );

  always_comb begin
    w_own   = OWN_NONE;
    w_addr  = r_sram_addr;
    w_we    = 1'b0;
    w_wdata = r_sram_wdata;
    w_oor   = 1'b0;
    if (bus.disp_req) begin
      w_own  = OWN_DISP;
      w_addr = bus.disp_addr;
      w_oor  = w_disp_oor;
    end else if (w_wr_fire) begin
      w_own   = OWN_WR;
      w_addr  = bus.wr_addr;
      w_wdata = bus.wr_data;
      w_we    = !w_wr_oor;
      w_oor   = w_wr_oor;
    end else if (w_rd_fire) begin
      w_own  = OWN_RD;
      w_addr = bus.rd_addr;
      w_oor  = w_rd_oor;
    end else if (w_fill_req) begin
      w_own   = OWN_FILL;
      w_addr  = w_fill_addr;
      w_wdata = w_fill_data;
      w_we    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_rd     <= 1'b1;
      r_own1        <= OWN_NONE;
      r_own2        <= OWN_NONE;
      r_oor1        <= 1'b0;
      r_oor2        <= 1'b0;
      r_sram_addr   <= '0;
      r_sram_we     <= 1'b0;
      r_sram_wdata  <= '0;
      r_disp_rdata  <= '0;
      r_disp_rvalid <= 1'b0;
      r_rd_rdata    <= '0;
      r_rd_rvalid   <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      r_sram_addr  <= w_addr;
      r_sram_we    <= w_we;
      r_sram_wdata <= w_wdata;
      r_own1       <= w_own;
      r_oor1       <= w_oor;
      r_own2       <= r_own1;
      r_oor2       <= r_oor1;
      if (w_wr_fire || w_rd_fire) r_last_rd <= !r_last_rd;

      // SRAM data for the stage-2 owner is on sram_rdata now
      r_disp_rvalid <= (r_own2 == OWN_DISP);
      r_rd_rvalid   <= (r_own2 == OWN_RD);
      if (r_own2 == OWN_DISP) r_disp_rdata <= r_oor2 ? '0 : bus.sram_rdata;
      if (r_own2 == OWN_RD)   r_rd_rdata   <= r_oor2 ? '0 : bus.sram_rdata;

      if (w_err)            r_addr_err <= 1'b1;
      else if (bus.err_clr) r_addr_err <= 1'b0;
    end
  end

  assign bus.wr_ready    = w_wr_ready;
  assign bus.rd_ready    = w_rd_ready;
  assign bus.sram_addr   = r_sram_addr;
  assign bus.sram_we     = r_sram_we;
  assign bus.sram_wdata  = r_sram_wdata;
  assign bus.disp_rdata  = r_disp_rdata;
  assign bus.disp_rvalid = r_disp_rvalid;
  assign bus.rd_rdata    = r_rd_rdata;
  assign bus.rd_rvalid   = r_rd_rvalid;
  assign bus.fill_busy   = w_fill_busy;
  assign bus.fill_done   = w_fill_done;
  assign bus.addr_err    = r_addr_err;

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter with a 1-cycle-latency SRAM model.
// DEPTH is scaled down so full-buffer fills stay short.
module tb_fb_arbiter;

  localparam int unsigned AW    = 17;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1000;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  exp_t q_disp[$];
  exp_t q_rd[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int cyc      = 0;
  int k, t0, wi, ri;
  int wa[2] = '{30, 31};
  int ra[2] = '{40, 41};
  logic [DW-1:0] wd[2] = '{8'hA0, 8'hA1};
  logic ew[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic er[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model; out-of-range reads return a poison value the DUT must mask
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
    end else if (bus.sram_we && bus.sram_addr < AW'(DEPTH)) begin
      mem[bus.sram_addr] <= bus.sram_wdata;
    end
    bus.sram_rdata <= (bus.sram_addr < AW'(DEPTH)) ? mem[bus.sram_addr] : 8'hEE;
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus.disp_rvalid) begin
      if (q_disp.size() == 0) chk("disp_unexpected_rvalid", 32'(bus.disp_rvalid), 0);
      else begin
        e = q_disp.pop_front();
        chk("disp_rdata", 32'(bus.disp_rdata), 32'(e.data));
        chk("disp_latency", cyc, e.cyc);
      end
    end
    if (bus.rd_rvalid) begin
      if (q_rd.size() == 0) chk("rd_unexpected_rvalid", 32'(bus.rd_rvalid), 0);
      else begin
        e = q_rd.pop_front();
        chk("rd_rdata", 32'(bus.rd_rdata), 32'(e.data));
        chk("rd_latency", cyc, e.cyc);
      end
    end
    if (reset && bus.sram_we) chk("sram_we_in_range", 32'(bus.sram_addr < AW'(DEPTH)), 1);
    if (bus.fill_done) n_done++;
  end

  task automatic host_write(input int addr, input logic [DW-1:0] data);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(addr);
    bus.wr_data  = data;
    #1;
    chk("wr_ready", 32'(bus.wr_ready), 1);
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic host_read(input int addr, input logic [DW-1:0] exp);
    bus.rd_valid = 1'b1;
    bus.rd_addr  = AW'(addr);
    q_rd.push_back('{exp, cyc + 3});
    #1;
    chk("rd_ready", 32'(bus.rd_ready), 1);
    @(negedge clk);
    bus.rd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bus.disp_req = 0; bus.disp_addr = '0;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 0; bus.rd_addr = '0;
    bus.fill_start = 0; bus.fill_value = '0; bus.err_clr = 0;

    // reset state, readies forced low even with both valids up
    repeat (3) @(negedge clk);
    bus.wr_valid = 1; bus.rd_valid = 1;
    #1;
    chk("rst_wr_ready", 32'(bus.wr_ready), 0);
    chk("rst_rd_ready", 32'(bus.rd_ready), 0);
    chk("rst_sram_we", 32'(bus.sram_we), 0);
    chk("rst_disp_rvalid", 32'(bus.disp_rvalid), 0);
    chk("rst_fill_busy", 32'(bus.fill_busy), 0);
    chk("rst_addr_err", 32'(bus.addr_err), 0);
    bus.wr_valid = 0; bus.rd_valid = 0;
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);

    // display back-to-back over 0..9
    for (int i = 0; i < 10; i++) begin
      bus.disp_req = 1; bus.disp_addr = AW'(i);
      q_disp.push_back('{8'(i), cyc + 3});
      @(negedge clk);
    end
    bus.disp_req = 0;
    repeat (4) @(negedge clk);

    // simple host traffic, even number of transfers keeps last_rd at 1
    host_write(20, 8'h55);
    host_read(20, 8'h55);
    host_write(22, 8'h66);
    host_read(21, 8'd21);
    repeat (4) @(negedge clk);

    // contention: display blocks cycle 0, then W,R,W,R
    wi = 0; ri = 0;
    for (int c = 0; c < 5; c++) begin
      bus.disp_req  = (c == 0);
      bus.disp_addr = AW'(5);
      if (c == 0) q_disp.push_back('{8'd5, cyc + 3});
      bus.wr_valid = (wi < 2);
      bus.wr_addr  = AW'(wa[(wi < 2) ? wi : 1]);
      bus.wr_data  = wd[(wi < 2) ? wi : 1];
      bus.rd_valid = (ri < 2);
      bus.rd_addr  = AW'(ra[(ri < 2) ? ri : 1]);
      #1;
      chk("cont_wr_ready", 32'(bus.wr_ready), 32'(ew[c]));
      chk("cont_rd_ready", 32'(bus.rd_ready), 32'(er[c]));
      if (er[c]) q_rd.push_back('{8'(ra[ri]), cyc + 3});
      @(negedge clk);
      if (ew[c]) wi++;
      if (er[c]) ri++;
    end
    bus.wr_valid = 0; bus.rd_valid = 0; bus.disp_req = 0;
    host_read(30, 8'hA0);
    host_read(31, 8'hA1);
    repeat (4) @(negedge clk);

    // fill 0xC8 alone; restart attempt mid-fill must be ignored
    bus.fill_value = 8'hC8; bus.fill_start = 1; t0 = cyc;
    @(negedge clk);
    bus.fill_start = 0; bus.fill_value = 8'h00;
    chk("fill_busy_rise", 32'(bus.fill_busy), 1);
    k = 1;
    while (!bus.fill_done && k < 2 * DEPTH) begin
      bus.fill_start = (k == 10);
      bus.fill_value = (k == 10) ? 8'h01 : 8'h00;
      @(negedge clk);
      k++;
    end
    bus.fill_start = 0;
    chk("fill_done_seen", 32'(bus.fill_done), 1);
    chk("fill_elapsed", 32'(cyc - t0), DEPTH + 1);
    chk("fill_busy_fall", 32'(bus.fill_busy), 0);
    @(negedge clk);
    chk("fill_done_pulse", 32'(bus.fill_done), 0);
    host_read(0, 8'hC8);
    host_read(DEPTH / 2, 8'hC8);
    host_read(DEPTH - 1, 8'hC8);
    repeat (4) @(negedge clk);
    chk("fill_done_count1", n_done, 1);

    // fill 0x3C with display on every other cycle and one host write
    bus.fill_value = 8'h3C; bus.fill_start = 1; t0 = cyc;
    @(negedge clk);
    bus.fill_start = 0;
    k = 1;
    while (!bus.fill_done && k < 3 * DEPTH) begin
      bus.disp_req  = (k % 2 == 0);
      bus.disp_addr = '0;
      if (k % 2 == 0) q_disp.push_back('{8'h3C, cyc + 3});
      bus.wr_valid = (k == 401);
      bus.wr_addr  = AW'(100);
      bus.wr_data  = 8'h11;
      if (k == 401) begin
        #1;
        chk("fill50_wr_ready", 32'(bus.wr_ready), 1);
      end
      @(negedge clk);
      k++;
    end
    bus.disp_req = 0; bus.wr_valid = 0;
    chk("fill50_done_seen", 32'(bus.fill_done), 1);
    chk("fill50_elapsed", 32'(cyc - t0), 2 * DEPTH + 2);
    host_read(100, 8'h11);
    host_read(101, 8'h3C);
    host_read(DEPTH - 1, 8'h3C);
    repeat (4) @(negedge clk);
    chk("fill_done_count2", n_done, 2);

    // out-of-range write and read
    host_write(DEPTH, 8'hAB);
    host_read(DEPTH, 8'h00);
    repeat (3) @(negedge clk);
    chk("oor_addr_err_set", 32'(bus.addr_err), 1);
    bus.err_clr = 1;
    @(negedge clk);
    bus.err_clr = 0;
    chk("oor_addr_err_clr", 32'(bus.addr_err), 0);
    bus.err_clr = 1; bus.disp_req = 1; bus.disp_addr = AW'(DEPTH);
    q_disp.push_back('{8'h00, cyc + 3});
    @(negedge clk);
    bus.err_clr = 0; bus.disp_req = 0;
    chk("oor_err_beats_clr", 32'(bus.addr_err), 1);
    bus.err_clr = 1;
    @(negedge clk);
    bus.err_clr = 0;
    chk("oor_addr_err_clr2", 32'(bus.addr_err), 0);
    repeat (4) @(negedge clk);

    // reset at fill counter ~500 with a display read in flight
    bus.fill_value = 8'h77; bus.fill_start = 1;
    @(negedge clk);
    bus.fill_start = 0;
    repeat (500) @(negedge clk);
    bus.disp_req = 1; bus.disp_addr = AW'(5);
    @(negedge clk);
    bus.disp_req = 0;
    reset = 0;
    #1;
    chk("mid_rst_sram_we", 32'(bus.sram_we), 0);
    chk("mid_rst_sram_addr", 32'(bus.sram_addr), 0);
    chk("mid_rst_sram_wdata", 32'(bus.sram_wdata), 0);
    chk("mid_rst_fill_busy", 32'(bus.fill_busy), 0);
    chk("mid_rst_fill_done", 32'(bus.fill_done), 0);
    chk("mid_rst_disp_rvalid", 32'(bus.disp_rvalid), 0);
    chk("mid_rst_rd_rdata", 32'(bus.rd_rdata), 0);
    repeat (4) @(negedge clk);
    reset = 1;
    repeat (5) @(negedge clk);
    chk("post_rst_fill_busy", 32'(bus.fill_busy), 0);
    chk("post_rst_sram_we", 32'(bus.sram_we), 0);
    chk("post_rst_done_count", n_done, 2);

    repeat (4) @(negedge clk);
    chk("disp_queue_drained", q_disp.size(), 0);
    chk("rd_queue_drained", q_rd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Arbitrates the single-port 300x300 8-bit frame-buffer SRAM among the VGA display fetch, a host write port, a host read port and an internal fill engine. The display port has absolute priority and fixed latency, so the video controller never sees a missed pixel. The host write and read ports share the remaining slots round-robin, and the fill engine uses idle slots. The block sits between the video controller and the frame-buffer SRAM instance.

## Interface
- ADDR_W, 17, SRAM address width
- DATA_W, 8, pixel width
- DEPTH, 90000, valid word count; addresses >= DEPTH are out of range
- clk  in  1  system clock; every port is synchronous to it
- reset  in  1  asynchronous, active-low reset
- disp_req  in  1  display fetch request; may be asserted every cycle
- disp_addr  in  ADDR_W  display fetch address
- disp_rdata  out  DATA_W  display read data
- disp_rvalid  out  1  one-cycle pulse qualifying disp_rdata
- wr_valid / wr_ready  in / out  1  host write handshake
- wr_addr, wr_data  in  ADDR_W, DATA_W  host write address and data
- rd_valid / rd_ready  in / out  1  host read handshake
- rd_addr  in  ADDR_W  host read address
- rd_rdata  out  DATA_W  host read data
- rd_rvalid  out  1  one-cycle pulse qualifying rd_rdata
- fill_start  in  1  pulse that starts a fill of the whole buffer
- fill_value  in  DATA_W  fill value, sampled on fill_start
- fill_busy  out  1  high while a fill is running
- fill_done  out  1  one-cycle pulse after the final fill write
- addr_err  out  1  sticky out-of-range flag
- err_clr  in  1  clears addr_err
- sram_addr, sram_we, sram_wdata  out  ADDR_W, 1, DATA_W  registered SRAM controls
- sram_rdata  in  DATA_W  SRAM read data; SRAM read latency is 1 cycle

## Operation
- Priority per cycle: display, then host write/read (round-robin), then fill.
- wr_ready = !disp_req && (!rd_valid || last_rd).
- rd_ready = !disp_req && (!wr_valid || !last_rd).
- Neither ready depends on its own valid.
- last_rd toggles only on an accepted host transfer (valid && ready); it resets to 1, so the first contended grant goes to write.
- Transfer rule: valid && ready at a rising edge. A host may hold valid across any number of stall cycles with address and data stable.
- Fill FSM has two states:
  - F_IDLE: fill_start captures fill_value, clears the counter to 0 and moves to F_RUN.
  - F_RUN: writes counter to sram_addr in every cycle that no display request or host transfer is present, then increments the counter. After the write to DEPTH-1 it pulses fill_done and returns to F_IDLE.
- fill_start while busy: ignored.
- Host write during fill: allowed. Last write to an address wins, so the fill can overwrite it if its counter has not yet passed that address.
- Out-of-range address (>= DEPTH) on any port:
  - The transfer is still accepted, and no SRAM write occurs.
  - Reads return 0, with rvalid still pulsed.
  - addr_err sets.
- err_clr and a new error in the same cycle: the error wins, so addr_err stays 1.
- Owner tag (NONE/DISP/RD/WR/FILL) plus an out-of-range bit are pipelined 2 stages alongside the SRAM access to steer the returned data.

## Timing
- Request sampled at edge E0: sram_addr and sram_we are valid after E0, and the SRAM captures at E1.
- disp_rdata/disp_rvalid (or rd_rdata/rd_rvalid) are registered at E2, so read latency is 2 cycles, fixed and unconditional.
- Back-to-back requests pipeline at full rate: one access per cycle.
- Reset (asynchronous assert):
  - All registered outputs are 0, including sram_we, disp_rvalid, rd_rvalid, fill_busy, fill_done and addr_err.
  - The FSM goes to F_IDLE and the counter to 0.
  - In-flight reads are discarded, with no rvalid.
  - wr_ready and rd_ready are forced 0 while reset is low.
- Reset mid-fill aborts the fill with no fill_done. Reset deassertion takes effect on the next edge.
- fill_busy rises after the fill_start edge and falls in the same cycle that fill_done pulses.

## Structure
- Package fb_arb_pkg holds:
  - owner_t enum {OWN_NONE, OWN_DISP, OWN_RD, OWN_WR, OWN_FILL}
  - fill_state_t {F_IDLE, F_RUN}
  - default ADDR_W/DATA_W/DEPTH localparams
- Sub-module fb_fill_engine contains the fill FSM and counter. It takes a slot-available input and outputs a request, an address, the fill data, busy and done.
- The arbiter logic and the 2-stage return pipeline stay in fb_arbiter.

## Test plan
- Display-only reads: disp_req every cycle over addresses 0..9, with SRAM preloaded with addr&0xFF. disp_rdata equals 0..9 exactly 2 cycles after each request, with no gaps in disp_rvalid.
- Contention: wr_valid and rd_valid held high with disp_req low. Grants alternate W, R, W, R, starting with W. With disp_req high, both readies are 0 and the held transfers complete once disp_req drops.
- Fill: fill_start with value 0xC8 and no other traffic. After DEPTH cycles fill_done pulses once and fill_busy falls. A readback of addresses 0, 45000 and 89999 returns 0xC8.
- Fill with interleaved display traffic at 50% duty: the fill takes about 2*DEPTH cycles. A host write of 0x11 to address 100 after the counter has passed 100 reads back 0x11.
- Out of range: a write to 90000 followed by a read from 90000. There is no SRAM write, the read returns 0 with rvalid, and addr_err=1. err_clr then drives addr_err to 0.
- Assert reset at fill counter 500 with a display read in flight. All outputs are 0 and no rvalid or fill_done pulse appears. After release, fill_busy stays 0.
